// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline stages.
// The fetch stage uses them for word width, PC stepping and the bubble encoding.
package mips_pkg;

  localparam int          WORD_W             = 32;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] PC_STEP            = 32'd4;
  localparam int          IMEM_WORDS_DEFAULT = 256;

endpackage

// File: rtl/if_fetch_unit_instruction_rom.sv
// Word-addressed instruction store with a combinational read port.
// The contents are loaded from outside through a hierarchical path.
module instruction_rom
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
  input  logic [WORD_W-3:0] word_addr,
  output logic [WORD_W-1:0] word,
  output logic              out_of_range
);

  localparam int AW = $clog2(IMEM_WORDS);

  logic [WORD_W-1:0] instruction_memory [0:IMEM_WORDS-1];

  // Any word-address bit above the array index means the fetch is past the end of memory.
  assign word         = instruction_memory[word_addr[AW-1:0]];
  assign out_of_range = (word_addr >> AW) != 30'd0;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: holds the program counter and drives the IF/ID pipeline register.
// A taken branch redirects the PC and flushes IF/ID; a stall freezes both.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] PC,
  output logic [31:0] ID_new_pc_value,
  output logic [31:0] ID_instruction,
  output logic        ID_valid,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  logic [31:0] rom_word_s;
  logic        rom_oor_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] pc_next_s;
  logic [31:0] npc_next_s;
  logic [31:0] inst_next_s;
  logic        valid_next_s;
  logic [31:0] count_next_s;
  logic        fault_next_s;

  instruction_rom #(.IMEM_WORDS(IMEM_WORDS)) u_rom (
    .word_addr    (PC[31:2]),
    .word         (rom_word_s),
    .out_of_range (rom_oor_s)
  );

  assign pc_plus4_s = PC + PC_STEP;

  // Next-state selection: branch beats stall, stall beats a normal fetch.
  always_comb begin
    pc_next_s    = PC;
    npc_next_s   = ID_new_pc_value;
    inst_next_s  = ID_instruction;
    valid_next_s = ID_valid;
    count_next_s = fetch_count;
    fault_next_s = fetch_fault;
    if (branch_taken) begin
      pc_next_s    = {branch_address[31:2], 2'b00};
      npc_next_s   = 32'd0;
      inst_next_s  = NOP_INSTR;
      valid_next_s = 1'b0;
    end else if (stall) begin
      pc_next_s = PC;
    end else begin
      pc_next_s = pc_plus4_s;
      if (rom_oor_s) begin
        npc_next_s   = 32'd0;
        inst_next_s  = NOP_INSTR;
        valid_next_s = 1'b0;
        fault_next_s = 1'b1;
      end else begin
        npc_next_s   = pc_plus4_s;
        inst_next_s  = rom_word_s;
        valid_next_s = 1'b1;
        count_next_s = fetch_count + 32'd1;
      end
    end
  end

  // PC, IF/ID register and fetch statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC              <= RESET_PC;
      ID_new_pc_value <= 32'd0;
      ID_instruction  <= NOP_INSTR;
      ID_valid        <= 1'b0;
      fetch_count     <= 32'd0;
      fetch_fault     <= 1'b0;
    end else begin
      PC              <= pc_next_s;
      ID_new_pc_value <= npc_next_s;
      ID_instruction  <= inst_next_s;
      ID_valid        <= valid_next_s;
      fetch_count     <= count_next_s;
      fetch_fault     <= fault_next_s;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed steps plus random stall/branch
// traffic compared against a transaction-level model of the fetch stage.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] pc;
  logic [31:0] id_npc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [31:0] fcount;
  logic        ffault;

  logic        reset4;
  logic        stall4;
  logic        branch4;
  logic [31:0] baddr4;
  logic [31:0] pc4;
  logic [31:0] id_npc4;
  logic [31:0] id_inst4;
  logic        id_valid4;
  logic [31:0] fcount4;
  logic        ffault4;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [0:255];
  logic [31:0] mem4 [0:3];

  logic [31:0] m_pc, m_npc, m_inst, m_count;
  logic        m_valid, m_fault;

  if_fetch_unit #(.IMEM_WORDS(256), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_address(branch_address), .PC(pc), .ID_new_pc_value(id_npc),
    .ID_instruction(id_inst), .ID_valid(id_valid), .fetch_count(fcount),
    .fetch_fault(ffault)
  );

  if_fetch_unit #(.IMEM_WORDS(4), .RESET_PC(32'h0000_0000)) dut4 (
    .clk(clk), .reset(reset4), .stall(stall4), .branch_taken(branch4),
    .branch_address(baddr4), .PC(pc4), .ID_new_pc_value(id_npc4),
    .ID_instruction(id_inst4), .ID_valid(id_valid4), .fetch_count(fcount4),
    .fetch_fault(ffault4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc,              m_pc);
    chk({tag, ".npc"},   id_npc,          m_npc);
    chk({tag, ".inst"},  id_inst,         m_inst);
    chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, m_valid});
    chk({tag, ".count"}, fcount,          m_count);
    chk({tag, ".fault"}, {31'd0, ffault},  {31'd0, m_fault});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_npc = 32'h0; m_inst = 32'h0;
    m_valid = 1'b0; m_count = 32'h0; m_fault = 1'b0;
  endtask

  // One clock edge of the fetch stage as described by its rules.
  task automatic model_tick(input logic s, input logic b, input logic [31:0] a);
    if (b) begin
      m_pc = a & 32'hFFFF_FFFC;
      m_npc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      if (m_pc >= 32'd1024) begin
        m_npc = 32'h0; m_inst = 32'h0; m_valid = 1'b0; m_fault = 1'b1;
      end else begin
        m_npc = m_pc + 32'd4; m_inst = mem[m_pc / 4]; m_valid = 1'b1;
        m_count = m_count + 32'd1;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step(input string tag, input logic s, input logic b, input logic [31:0] a);
    stall = s; branch_taken = b; branch_address = a;
    @(posedge clk);
    model_tick(s, b, a);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // Reset is applied between edges and must act immediately.
  task automatic do_reset(input string tag);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_address = 32'h0;
    reset4 = 1'b1; stall4 = 1'b1; branch4 = 1'b0; baddr4 = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2109_0002; mem[1] = 32'h210A_0007;
    mem[2] = 32'h210B_0008; mem[3] = 32'h0000_0000;
    for (int i = 0; i < 256; i++) dut.u_rom.instruction_memory[i] = mem[i];
    for (int i = 0; i < 4; i++) begin
      mem4[i] = $urandom | 32'h1;
      dut4.u_rom.instruction_memory[i] = mem4[i];
    end
    model_reset();
    #1;
    check_all("reset_init");
    @(negedge clk);
    reset = 1'b0;

    // Free-running fetch of the first four words.
    for (int i = 0; i < 4; i++) step("free", 1'b0, 1'b0, 32'h0);
    chk("free_count4", fcount, 32'd4);
    chk("free_npc16", id_npc, 32'd16);

    // Stall for three edges after edge 2, then release.
    do_reset("reset_stall");
    step("stall_pre", 1'b0, 1'b0, 32'h0);
    step("stall_pre", 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("stall_hold", 1'b1, 1'b0, 32'h0);
      chk("stall_pc8", pc, 32'h8);
      chk("stall_word1", id_inst, 32'h210A_0007);
    end
    step("stall_rel", 1'b0, 1'b0, 32'h0);
    chk("stall_word2", id_inst, 32'h210B_0008);
    step("stall_rel", 1'b0, 1'b0, 32'h0);

    // Taken branch at edge 3 to a misaligned target.
    do_reset("reset_br");
    step("br_pre", 1'b0, 1'b0, 32'h0);
    step("br_pre", 1'b0, 1'b0, 32'h0);
    step("br_take", 1'b0, 1'b1, 32'h0000_0022);
    chk("br_pc", pc, 32'h20);
    chk("br_bubble", {31'd0, id_valid}, 32'd0);
    step("br_target", 1'b0, 1'b0, 32'h0);
    chk("br_npc24", id_npc, 32'h24);

    // Branch together with stall: branch wins.
    step("brst_pre", 1'b1, 1'b0, 32'h0);
    step("brst", 1'b1, 1'b1, 32'h0000_0100);
    chk("brst_pc", pc, 32'h100);
    step("brst_post", 1'b0, 1'b0, 32'h0);

    // Wrap-around from the top of the address space.
    step("wrap_br", 1'b0, 1'b1, 32'hFFFF_FFFE);
    step("wrap_oor", 1'b0, 1'b0, 32'h0);
    chk("wrap_pc0", pc, 32'h0);
    step("wrap_refetch", 1'b0, 1'b0, 32'h0);

    // Mid-run reset clears the sticky fault and restarts at RESET_PC.
    do_reset("reset_mid");
    step("reset_refetch", 1'b0, 1'b0, 32'h0);
    chk("reset_word0", id_inst, 32'h2109_0002);

    // Small memory: fifth fetch runs off the end.
    stall = 1'b1; branch_taken = 1'b0;
    #1 reset4 = 1'b1;
    #1 stall4 = 1'b0;
    reset4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) begin
        chk("small_inst", id_inst4, mem4[i]);
        chk("small_npc", id_npc4, 32'(4 * (i + 1)));
        chk("small_valid", {31'd0, id_valid4}, 32'd1);
        chk("small_fault0", {31'd0, ffault4}, 32'd0);
      end else begin
        chk("small_oor_inst", id_inst4, 32'h0);
        chk("small_oor_valid", {31'd0, id_valid4}, 32'd0);
        chk("small_oor_fault", {31'd0, ffault4}, 32'd1);
        chk("small_oor_count", fcount4, 32'd4);
        chk("small_oor_pc", pc4, 32'(4 * (i + 1)));
      end
    end
    @(negedge clk);

    // Random stall/branch traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic        rs;
      logic        rb;
      logic [31:0] ra;
      rs = ($urandom_range(0, 3) == 0);
      rb = ($urandom_range(0, 9) == 0);
      ra = 32'($urandom_range(0, 1100));
      step("rand", rs, rb, ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
